// File: rtl/njesia_pjesetimit_if.sv
// ============================================================================
// Module  : njesia_pjesetimit_if
// Brief   : Request/result bundle between the ALU and the iterative divider.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface njesia_pjesetimit_if #(
    parameter int WIDTH = 16
);
    logic             Start;
    logic [WIDTH-1:0] Hyrja1;
    logic [WIDTH-1:0] Hyrja2;
    logic [WIDTH-1:0] Heresi;
    logic [WIDTH-1:0] Mbetja;
    logic             Gati;
    logic             Zene;
    logic             PjeseZero;

    modport master (
        output Start, Hyrja1, Hyrja2,
        input  Heresi, Mbetja, Gati, Zene, PjeseZero
    );

    modport slave (
        input  Start, Hyrja1, Hyrja2,
        output Heresi, Mbetja, Gati, Zene, PjeseZero
    );
endinterface

`default_nettype wire

// File: rtl/njesia_pjesetimit.sv
// ============================================================================
// Module  : njesia_pjesetimit
// Brief   : Iterative restoring unsigned divider, one quotient bit per clock.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module njesia_pjesetimit #(
    parameter int WIDTH = 16
) (
    input  wire logic            Clock,
    input  wire logic            Reset,
    njesia_pjesetimit_if.slave   bus
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] heresi_q, heresi_d;
    logic [WIDTH-1:0] mbetja_q, mbetja_d;
    logic             pz_q, pz_d;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_sub;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quot_next;
    logic             fit;

    // One restoring step: pull next dividend bit into R, subtract B if it fits.
    always_comb begin
        rem_shift = {rem_q[WIDTH-1:0], quot_q[WIDTH-1]};
        rem_sub   = rem_shift - {1'b0, div_q};
        fit       = (rem_shift >= {1'b0, div_q});
        rem_next  = fit ? rem_sub : rem_shift;
        quot_next = {quot_q[WIDTH-2:0], fit};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        quot_d   = quot_q;
        div_d    = div_q;
        rem_d    = rem_q;
        heresi_d = heresi_q;
        mbetja_d = mbetja_q;
        pz_d     = pz_q;

        case (state_q)
            S_RUN: begin
                quot_d = quot_next;
                rem_d  = rem_next;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d  = S_DONE;
                    heresi_d = quot_next;
                    mbetja_d = rem_next[WIDTH-1:0];
                    pz_d     = 1'b0;
                end
            end
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.Start) begin
                    if (bus.Hyrja2 == '0) begin
                        // Divide by zero finishes immediately with a saturated quotient.
                        state_d  = S_DONE;
                        heresi_d = '1;
                        mbetja_d = bus.Hyrja1;
                        pz_d     = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        quot_d  = bus.Hyrja1;
                        div_d   = bus.Hyrja2;
                        rem_d   = '0;
                        cnt_d   = CW'(WIDTH);
                        pz_d    = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            quot_q   <= '0;
            div_q    <= '0;
            rem_q    <= '0;
            heresi_q <= '0;
            mbetja_q <= '0;
            pz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            quot_q   <= quot_d;
            div_q    <= div_d;
            rem_q    <= rem_d;
            heresi_q <= heresi_d;
            mbetja_q <= mbetja_d;
            pz_q     <= pz_d;
        end
    end

    assign bus.Heresi    = heresi_q;
    assign bus.Mbetja    = mbetja_q;
    assign bus.PjeseZero = pz_q;
    assign bus.Gati      = (state_q == S_DONE);
    assign bus.Zene      = (state_q == S_RUN);

endmodule

`default_nettype wire
